ssram_wbuf: RTL and testbench

Write-posting request buffer that sits directly upstream of the serial SRAM controller. It accepts single-byte CPU-side read/write requests, posts writes into a small FIFO so the CPU is released immediately, and drains them to the controller one at a time over a valid/ready handshake. Reads are forwarded from the FIFO on an address hit; on a miss they are issued only after all posted writes have drained, which preserves program order.

---
 rtl/ssram_wbuf.sv | 178 +++++++++++++++++
 tb/tb_ssram_wbuf.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssram_wbuf.sv
// Write-posting request buffer in front of the serial SRAM controller.
// Posts CPU writes into a small FIFO, forwards reads on address hits and drains to memory in order.
module ssram_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 19
) (
  input  logic                      clk_136m,
  input  logic                      reset_n,
  input  logic                      cpu_req,
  input  logic                      cpu_write,
  input  logic [ADDR_W-1:0]         cpu_address,
  input  logic [7:0]                cpu_wdata,
  output logic                      cpu_busy,
  output logic [7:0]                cpu_rdata,
  output logic                      cpu_rdata_en,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  input  logic                      mem_rdata_en
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, W_REQ, W_DONE, R_REQ, R_DONE} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   head_reg, tail_reg;
  logic [LVL_W-1:0]   level_reg;
  logic [ADDR_W-1:0]  addr_mem [DEPTH];
  logic [7:0]         data_mem [DEPTH];
  logic               read_pending_reg;
  logic [ADDR_W-1:0]  rd_addr_reg;
  logic [7:0]         cpu_rdata_reg;
  logic               cpu_rdata_en_reg;
  logic               mem_write_reg;
  logic [ADDR_W-1:0]  mem_address_reg;
  logic [7:0]         mem_wdata_reg;

  logic               full, accept, push, rd_accept;
  logic               load_w, load_r, pop, rd_done;
  logic [DEPTH-1:0]   addr_match;
  logic               fwd_hit;
  logic [7:0]         fwd_data;
  logic [PTR_W-1:0]   fwd_idx;
  logic [ADDR_W-1:0]  head_addr;
  logic [7:0]         head_data;

  assign full      = (level_reg == LVL_W'(DEPTH));
  assign cpu_busy  = full | read_pending_reg;
  assign accept    = cpu_req & ~cpu_busy;
  assign push      = accept & cpu_write;
  assign rd_accept = accept & ~cpu_write;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign addr_match[gi] = (addr_mem[gi] == cpu_address);
    end
  endgenerate

  // Walk entries oldest to newest so the youngest matching write wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 8'h00;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_reg + PTR_W'(k);
      if ((LVL_W'(k) < level_reg) && addr_match[fwd_idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

  // With an empty FIFO the incoming write is issued straight from the CPU bus.
  assign head_addr = (level_reg == '0) ? cpu_address : addr_mem[head_reg];
  assign head_data = (level_reg == '0) ? cpu_wdata   : data_mem[head_reg];

  always_comb begin
    state_next = state_reg;
    load_w     = 1'b0;
    load_r     = 1'b0;
    pop        = 1'b0;
    rd_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (((level_reg != '0) || push) && mem_ready) begin
          load_w     = 1'b1;
          state_next = W_REQ;
        end else if (read_pending_reg && mem_ready) begin
          load_r     = 1'b1;
          state_next = R_REQ;
        end
      end
      W_REQ:   if (!mem_ready) state_next = W_DONE;
      R_REQ:   if (!mem_ready) state_next = R_DONE;
      W_DONE: begin
        if (mem_ready) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      R_DONE: begin
        if (mem_rdata_en) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_136m) begin
    if (push) begin
      addr_mem[tail_reg] <= cpu_address;
      data_mem[tail_reg] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk_136m) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      head_reg         <= '0;
      tail_reg         <= '0;
      level_reg        <= '0;
      read_pending_reg <= 1'b0;
      rd_addr_reg      <= '0;
      cpu_rdata_reg    <= 8'h00;
      cpu_rdata_en_reg <= 1'b0;
      mem_write_reg    <= 1'b0;
      mem_address_reg  <= '0;
      mem_wdata_reg    <= 8'h00;
    end else begin
      state_reg        <= state_next;
      cpu_rdata_en_reg <= 1'b0;
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      level_reg <= level_reg + LVL_W'(push) - LVL_W'(pop);
      if (rd_accept) begin
        if (fwd_hit) begin
          cpu_rdata_reg    <= fwd_data;
          cpu_rdata_en_reg <= 1'b1;
        end else begin
          read_pending_reg <= 1'b1;
          rd_addr_reg      <= cpu_address;
        end
      end
      if (rd_done) begin
        cpu_rdata_reg    <= mem_rdata;
        cpu_rdata_en_reg <= 1'b1;
        read_pending_reg <= 1'b0;
      end
      if (load_w) begin
        mem_write_reg   <= 1'b1;
        mem_address_reg <= head_addr;
        mem_wdata_reg   <= head_data;
      end else if (load_r) begin
        mem_write_reg   <= 1'b0;
        mem_address_reg <= rd_addr_reg;
        mem_wdata_reg   <= 8'h00;
      end
    end
  end

  assign mem_valid    = (state_reg == W_REQ) || (state_reg == R_REQ);
  assign mem_write    = mem_write_reg;
  assign mem_address  = mem_address_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign cpu_rdata    = cpu_rdata_reg;
  assign cpu_rdata_en = cpu_rdata_en_reg;
  assign fifo_level   = level_reg;

endmodule

// File: tb/tb_ssram_wbuf.sv
// Scoreboard bench for ssram_wbuf: behavioural controller model, expected memory
// requests and read data queued at stimulus time and checked as the DUT produces them.
module tb_ssram_wbuf;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 19;
  localparam int LVL_W    = $clog2(DEPTH) + 1;
  localparam int ACC_DLY  = 3;
  localparam int BUSY_DLY = 20;

  logic              clk_136m = 1'b0;
  logic              reset_n  = 1'b0;
  logic              cpu_req  = 1'b0;
  logic              cpu_write = 1'b0;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic [7:0]        cpu_wdata = 8'h00;
  logic              cpu_busy;
  logic [7:0]        cpu_rdata;
  logic              cpu_rdata_en;
  logic [LVL_W-1:0]  fifo_level;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_rdata_en;

  ssram_wbuf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_136m    (clk_136m),
    .reset_n     (reset_n),
    .cpu_req     (cpu_req),
    .cpu_write   (cpu_write),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_busy    (cpu_busy),
    .cpu_rdata   (cpu_rdata),
    .cpu_rdata_en(cpu_rdata_en),
    .fifo_level  (fifo_level),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rdata_en(mem_rdata_en)
  );

  always #4 clk_136m = ~clk_136m;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } mem_req_t;

  mem_req_t    exp_mem_q[$];
  logic [7:0]  exp_rd_q[$];
  int          checks = 0;
  int          errors = 0;

  bit          stall = 1'b0;
  bit          ctl_manual = 1'b0;
  int          ctl_st = 0;
  int          ctl_cnt = 0;
  logic        ctl_wr = 1'b0;
  logic [7:0]  rd_val = 8'h00;
  logic        prev_valid = 1'b0;

  // Controller model: ready falls ACC_DLY cycles after valid, rises BUSY_DLY cycles later.
  initial begin
    mem_ready    = 1'b1;
    mem_rdata_en = 1'b0;
    mem_rdata    = 8'h00;
    forever begin
      @(negedge clk_136m);
      if (ctl_manual) begin
        ctl_st = 0;
      end else begin
        mem_rdata_en = 1'b0;
        case (ctl_st)
          0: begin
            mem_ready = !stall;
            if (mem_valid === 1'b1 && mem_ready) begin
              ctl_st  = 1;
              ctl_cnt = 0;
            end
          end
          1: begin
            ctl_cnt++;
            if (ctl_cnt == ACC_DLY) begin
              mem_ready = 1'b0;
              ctl_wr    = mem_write;
              ctl_st    = 2;
              ctl_cnt   = 0;
            end
          end
          default: begin
            ctl_cnt++;
            if (ctl_cnt == BUSY_DLY) begin
              if (!ctl_wr) begin
                mem_rdata    = rd_val;
                mem_rdata_en = 1'b1;
              end
              mem_ready = 1'b1;
              ctl_st    = 0;
            end
          end
        endcase
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    mem_req_t e;
    logic [7:0] r;
    forever begin
      @(negedge clk_136m);
      if (mem_valid === 1'b1 && !prev_valid) begin
        checks++;
        if (exp_mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_issue unexpected: got wr=%0b addr=%05h data=%02h, required no request",
                   mem_write, mem_address, mem_wdata);
        end else begin
          e = exp_mem_q.pop_front();
          if (mem_write !== e.wr || mem_address !== e.addr || (e.wr && mem_wdata !== e.data)) begin
            errors++;
            $display("FAIL mem_issue: got wr=%0b addr=%05h data=%02h, required wr=%0b addr=%05h data=%02h",
                     mem_write, mem_address, mem_wdata, e.wr, e.addr, e.data);
          end
          if (!e.wr) begin
            checks++;
            if (fifo_level !== '0) begin
              errors++;
              $display("FAIL read_order: fifo_level=%0d at read issue, required 0", fifo_level);
            end
          end
        end
      end
      prev_valid = (mem_valid === 1'b1);
      if (cpu_rdata_en === 1'b1) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rdata unexpected: got cpu_rdata_en with %02h, required none", cpu_rdata);
        end else begin
          r = exp_rd_q.pop_front();
          if (cpu_rdata !== r) begin
            errors++;
            $display("FAIL rdata: got %02h, required %02h", cpu_rdata, r);
          end
        end
      end
      if (reset_n && fifo_level > LVL_W'(DEPTH)) begin
        checks++;
        errors++;
        $display("FAIL level_bound: fifo_level=%0d, required <= %0d", fifo_level, DEPTH);
      end
    end
  end

  task automatic cpu_op(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                        input logic exp_acc);
    mem_req_t e;
    @(negedge clk_136m);
    cpu_req     = 1'b1;
    cpu_write   = wr;
    cpu_address = a;
    cpu_wdata   = d;
    checks++;
    if (cpu_busy !== !exp_acc) begin
      errors++;
      $display("FAIL accept: cpu_busy=%0b for addr %05h, required %0b", cpu_busy, a, !exp_acc);
    end
    if (exp_acc && wr) begin
      e = '{wr: 1'b1, addr: a, data: d};
      exp_mem_q.push_back(e);
    end
    @(posedge clk_136m);
    #1 cpu_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk_136m);
      if (fifo_level == '0 && !cpu_busy && !mem_valid && ctl_st == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: fifo_level=%0d busy=%0b, required idle within %0d cycles",
               fifo_level, cpu_busy, bound);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_136m);
    @(negedge clk_136m);
    checks++;
    if ({cpu_busy, mem_valid, fifo_level, cpu_rdata, cpu_rdata_en, mem_write, mem_address, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b valid=%0b level=%0d rdata=%02h en=%0b, required all 0",
               cpu_busy, mem_valid, fifo_level, cpu_rdata, cpu_rdata_en);
    end
    reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    bit busy_seen = 1'b0;
    bit drained = 1'b0;
    cpu_op(1'b1, 19'h12345, 8'hA5, 1'b1);
    @(negedge clk_136m);
    checks++;
    if (mem_valid !== 1'b1 || mem_write !== 1'b1 || mem_address !== 19'h12345 || mem_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL single_issue: valid=%0b wr=%0b addr=%05h data=%02h, required 1 1 12345 a5",
               mem_valid, mem_write, mem_address, mem_wdata);
    end
    checks++;
    if (fifo_level !== LVL_W'(1)) begin
      errors++;
      $display("FAIL single_level: fifo_level=%0d, required 1", fifo_level);
    end
    for (int i = 0; i < 100 && !drained; i++) begin
      @(negedge clk_136m);
      if (cpu_busy !== 1'b0) busy_seen = 1'b1;
      if (fifo_level == '0) drained = 1'b1;
    end
    checks++;
    if (busy_seen || !drained) begin
      errors++;
      $display("FAIL single_drain: busy_seen=%0b drained=%0b, required 0 1", busy_seen, drained);
    end
    wait_idle(50);
    $display("test_single_write done");
  endtask

  task automatic test_fill_drop();
    stall = 1'b1;
    repeat (2) @(negedge clk_136m);
    for (int i = 0; i < DEPTH; i++)
      cpu_op(1'b1, 19'h00200 + ADDR_W'(i), 8'h80 + 8'(i), 1'b1);
    @(negedge clk_136m);
    checks++;
    if (cpu_busy !== 1'b1 || fifo_level !== LVL_W'(DEPTH)) begin
      errors++;
      $display("FAIL fill: busy=%0b level=%0d, required 1 %0d", cpu_busy, fifo_level, DEPTH);
    end
    cpu_op(1'b1, 19'h00300, 8'hEE, 1'b0);
    @(negedge clk_136m);
    checks++;
    if (fifo_level !== LVL_W'(DEPTH)) begin
      errors++;
      $display("FAIL drop: fifo_level=%0d after dropped write, required %0d", fifo_level, DEPTH);
    end
    stall = 1'b0;
    wait_idle(400);
    checks++;
    if (exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL fill_order: %0d writes not issued, required 0", exp_mem_q.size());
    end
    $display("test_fill_drop done");
  endtask

  task automatic test_forward();
    cpu_op(1'b1, 19'h00010, 8'h11, 1'b1);
    cpu_op(1'b1, 19'h00010, 8'h22, 1'b1);
    cpu_op(1'b1, 19'h00020, 8'h33, 1'b1);
    exp_rd_q.push_back(8'h22);
    cpu_op(1'b0, 19'h00010, 8'h00, 1'b1);
    @(negedge clk_136m);
    checks++;
    if (cpu_rdata_en !== 1'b1 || cpu_rdata !== 8'h22) begin
      errors++;
      $display("FAIL forward: en=%0b rdata=%02h one cycle after read, required 1 22",
               cpu_rdata_en, cpu_rdata);
    end
    wait_idle(300);
    $display("test_forward done");
  endtask

  task automatic test_miss();
    mem_req_t e;
    bit seen = 1'b0;
    rd_val = 8'h5A;
    cpu_op(1'b1, 19'h00400, 8'h01, 1'b1);
    cpu_op(1'b1, 19'h00401, 8'h02, 1'b1);
    e = '{wr: 1'b0, addr: 19'h7FFFF, data: 8'h00};
    exp_mem_q.push_back(e);
    exp_rd_q.push_back(8'h5A);
    cpu_op(1'b0, 19'h7FFFF, 8'h00, 1'b1);
    @(negedge clk_136m);
    checks++;
    if (cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL miss_busy: cpu_busy=%0b while read pending, required 1", cpu_busy);
    end
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk_136m);
      #1;
      if (mem_rdata_en === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || cpu_rdata_en !== 1'b1 || cpu_rdata !== 8'h5A || cpu_busy !== 1'b0) begin
      errors++;
      $display("FAIL miss_return: seen=%0b en=%0b rdata=%02h busy=%0b, required 1 1 5a 0",
               seen, cpu_rdata_en, cpu_rdata, cpu_busy);
    end
    wait_idle(100);
    $display("test_miss done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      for (int w = 0; w < 100 && cpu_busy; w++) @(negedge clk_136m);
      cpu_op(1'b1, 19'h00500 + ADDR_W'(i * 3), 8'h60 + 8'(i), 1'b1);
    end
    wait_idle(600);
    checks++;
    if (exp_mem_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_order: %0d writes not issued, required 0", exp_mem_q.size());
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    mem_req_t e;
    bit seen = 1'b0;
    bit late_en = 1'b0;
    ctl_manual = 1'b1;
    @(negedge clk_136m);
    mem_ready = 1'b1;
    e = '{wr: 1'b0, addr: 19'h0ABCD, data: 8'h00};
    exp_mem_q.push_back(e);
    cpu_op(1'b0, 19'h0ABCD, 8'h00, 1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_136m);
      if (mem_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_issue: mem_valid=%0b, required read issue within 20 cycles", mem_valid);
    end
    mem_ready = 1'b0;
    repeat (2) @(negedge clk_136m);
    reset_n = 1'b0;
    @(negedge clk_136m);
    checks++;
    if ({cpu_busy, mem_valid, fifo_level, cpu_rdata, cpu_rdata_en, mem_write, mem_address, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%0b valid=%0b level=%0d rdata=%02h addr=%05h, required all 0",
               cpu_busy, mem_valid, fifo_level, cpu_rdata, mem_address);
    end
    reset_n = 1'b1;
    mem_rdata = 8'h77;
    mem_rdata_en = 1'b1;
    @(negedge clk_136m);
    mem_rdata_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_136m);
      if (cpu_rdata_en !== 1'b0) late_en = 1'b1;
    end
    checks++;
    if (late_en) begin
      errors++;
      $display("FAIL late_rdata: cpu_rdata_en=1 after aborted read, required 0");
    end
    mem_ready  = 1'b1;
    ctl_manual = 1'b0;
    @(negedge clk_136m);
    cpu_op(1'b1, 19'h0F0F0, 8'h3C, 1'b1);
    @(negedge clk_136m);
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_write: mem_valid=%0b, required 1", mem_valid);
    end
    wait_idle(100);
    $display("test_reset_mid done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_fill_drop();
    test_forward();
    test_miss();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_mem_q.size() != 0 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: mem_q=%0d rd_q=%0d, required 0 0", exp_mem_q.size(), exp_rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
